// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: FSM state encoding, next-PC select encodings and default widths
//          shared by the controller, its comparator and its interface.
// Contents:
//   state_e      RUN / STALL / FLUSH
//   PCSEL_*      pc_sel encodings (PC+1, rs target, memory target)
//   *_DEF        default parameter values
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW_DEF       = 6;
  localparam int CNT_W_DEF        = 16;
  localparam int FLUSH_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] PCSEL_INC = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_MEM = 2'd2;

  // JumpMem wins over any other redirect source.
  function automatic logic [1:0] pc_sel_f(input logic jump_mem, input logic taken);
    if (jump_mem)   return PCSEL_MEM;
    else if (taken) return PCSEL_BR;
    else            return PCSEL_INC;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-stage status in, sequencing controls out
//
// Purpose: bundles the ID/EX/WB status seen by the hazard controller and the
//          controls it returns to the datapath.
// Signals:
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2   ID-stage sources
//   ex_rd, ex_regwrt, wb_rd, wb_regwrt                 pending destinations
//   wb_BranchZ, wb_BranchN, wb_Jump, wb_JumpMem        WB control bits
//   wb_N, wb_Z                                         WB ALU flags
//   pc_write, ifid_write, idex_bubble, flush, pc_sel   datapath controls
//   state, stall_cnt, flush_cnt                        debug / statistics
// Modports: slave = controller, master = datapath (or bench).
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrt;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrt;
  logic              wb_BranchZ;
  logic              wb_BranchN;
  logic              wb_Jump;
  logic              wb_JumpMem;
  logic              wb_N;
  logic              wb_Z;

  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic              flush;
  logic [1:0]        pc_sel;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_regwrt, wb_rd, wb_regwrt,
    input  wb_BranchZ, wb_BranchN, wb_Jump, wb_JumpMem, wb_N, wb_Z,
    output pc_write, ifid_write, idex_bubble, flush, pc_sel,
    output state, stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_regwrt, wb_rd, wb_regwrt,
    output wb_BranchZ, wb_BranchN, wb_Jump, wb_JumpMem, wb_N, wb_Z,
    input  pc_write, ifid_write, idex_bubble, flush, pc_sel,
    input  state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// rtl/pipe_hazard_ctrl_hazard_cmp.sv - one source register vs pending EX/WB destinations
//
// Purpose: flags a RAW dependency of a single ID source on an in-flight write.
// Ports:
//   src_i        source register address
//   use_i        instruction actually reads this source
//   ex_rd_i      EX-stage destination,  ex_regwrt_i  EX writes a register
//   wb_rd_i      WB-stage destination,  wb_regwrt_i  WB writes a register
//   hit_o        dependency present
module pipe_hazard_ctrl_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              use_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrt_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrt_i,
  output logic              hit_o
);

  // Register 0 is an ordinary register in this datapath, so no zero exemption.
  assign hit_o = use_i & ((ex_regwrt_i & (ex_rd_i == src_i)) |
                          (wb_regwrt_i & (wb_rd_i == src_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencing controller for the 5-stage datapath
//
// Purpose: stalls on RAW hazards (no forwarding), redirects and flushes on
//          taken WB-stage branches/jumps, keeps saturating statistics.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     pipe_hazard_ctrl_if.slave (stage status in, controls out)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hit_rs1, hit_rs2, hazard, taken;
  logic pc_write, ifid_write, idex_bubble, flush;
  logic stall_inc, flush_inc;

  pipe_hazard_ctrl_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
    .src_i       (bus.id_rs1),
    .use_i       (bus.id_use_rs1),
    .ex_rd_i     (bus.ex_rd),
    .ex_regwrt_i (bus.ex_regwrt),
    .wb_rd_i     (bus.wb_rd),
    .wb_regwrt_i (bus.wb_regwrt),
    .hit_o       (hit_rs1)
  );

  pipe_hazard_ctrl_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
    .src_i       (bus.id_rs2),
    .use_i       (bus.id_use_rs2),
    .ex_rd_i     (bus.ex_rd),
    .ex_regwrt_i (bus.ex_regwrt),
    .wb_rd_i     (bus.wb_rd),
    .wb_regwrt_i (bus.wb_regwrt),
    .hit_o       (hit_rs2)
  );

  assign hazard = bus.id_valid & (hit_rs1 | hit_rs2);
  assign taken  = bus.wb_Jump | bus.wb_JumpMem |
                  (bus.wb_BranchZ & bus.wb_Z) | (bus.wb_BranchN & bus.wb_N);

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    // A taken redirect wins in every state; in FLUSH it simply reloads the count.
    if (taken) begin
      flush     = 1'b1;
      fcnt_d    = FC_LOAD;
      flush_inc = 1'b1;
      state_d   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          // ID holds a squashed instruction, so its hazard is irrelevant here.
          flush       = 1'b1;
          idex_bubble = 1'b1;
          pc_write    = 1'b0;
          if (fcnt_q <= FC_W'(1)) begin
            fcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            fcnt_d  = fcnt_q - FC_W'(1);
          end
        end
        default: begin
          if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = ST_STALL;
          end else begin
            state_d     = ST_RUN;
          end
        end
      endcase
    end

    stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.idex_bubble = idex_bubble;
  assign bus.flush       = flush;
  assign bus.pc_sel      = pc_sel_f(bus.wb_JumpMem, taken);
  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule
